// File: rtl/mem_bank_timing.sv
// Multi-bank DRAM command timing checker: per-bank row state, tRRD/tFAW spacing, all-bank refresh.
// Define MEM_BANK_TIMING_AUTOPRE_EN to enable RDA/WRA with automatic precharge.
module mem_bank_timing #(
   parameter int unsigned NBANKS = 8,
   parameter int unsigned CW     = 8,
   parameter int unsigned RW     = 16,
   parameter int unsigned BL     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   input  logic [3:0]                cmd_op,
   input  logic [$clog2(NBANKS)-1:0] cmd_bank,
   input  logic [CW-1:0]             T_RCD,
   input  logic [CW-1:0]             T_RAS,
   input  logic [CW-1:0]             T_RP,
   input  logic [CW-1:0]             T_RTP,
   input  logic [CW-1:0]             T_WR,
   input  logic [CW-1:0]             T_CWL,
   input  logic [CW-1:0]             T_RRD,
   input  logic [CW-1:0]             T_FAW,
   input  logic [CW-1:0]             T_RFC,
   input  logic [RW-1:0]             T_REFI,
   output logic                      cmd_ok,
   output logic                      cmd_err,
   output logic [2*NBANKS-1:0]       bank_state,
   output logic                      refreshing,
   output logic                      refresh_due
);

   localparam int unsigned BW = $clog2(NBANKS);
   localparam logic [CW+1:0] SATMAX = {2'b00, {CW{1'b1}}};

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ACTIVATING  = 2'd1,
      ACTIVE      = 2'd2,
      PRECHARGING = 2'd3
   } bank_st_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ACT  = 4'd1,
      OP_RD   = 4'd2,
      OP_WR   = 4'd3,
      OP_PRE  = 4'd4,
      OP_PREA = 4'd5,
      OP_REF  = 4'd6,
      OP_RDA  = 4'd7,
      OP_WRA  = 4'd8
   } op_t;

   bank_st_t         st       [NBANKS];
   logic [CW-1:0]    rcd_ct   [NBANKS];
   logic [CW-1:0]    ras_ct   [NBANKS];
   logic [CW-1:0]    rp_ct    [NBANKS];
   logic [CW-1:0]    guard_ct [NBANKS];
   logic [CW-1:0]    faw_ct   [4];
   logic [CW-1:0]    rrd_ct;
   logic [CW-1:0]    rfc_ct;
   logic [RW-1:0]    refi_ct;

   logic             accept;
   logic             all_idle, prea_ready, faw_free;
   logic [1:0]       faw_sel;
   bank_st_t         b_st;
   logic             b_ready;
   logic             b_ap, any_ap;
   logic [CW+1:0]    wsum;
   logic [CW-1:0]    wr_sat;
   logic [CW-1:0]    rd_guard, wr_guard;

   function automatic logic [CW-1:0] nz(input logic [CW-1:0] t);
      return (t == '0) ? CW'(1) : t;
   endfunction

   function automatic logic [CW-1:0] dec(input logic [CW-1:0] c);
      return (c == '0) ? '0 : c - CW'(1);
   endfunction

   // Spacing counters hold the cycles left after the next edge, so a command
   // issued T cycles after its predecessor sees the counter at 0.
   function automatic logic [CW-1:0] ld(input logic [CW-1:0] t);
      return nz(t) - CW'(1);
   endfunction

   function automatic logic [CW-1:0] gmax(input logic [CW-1:0] g, input logic [CW-1:0] t);
      return (dec(g) > t) ? dec(g) : t;
   endfunction

`ifdef MEM_BANK_TIMING_AUTOPRE_EN
   logic [NBANKS-1:0] ap_pending;
   assign b_ap   = ap_pending[cmd_bank];
   assign any_ap = |ap_pending;
`else
   assign b_ap   = 1'b0;
   assign any_ap = 1'b0;
`endif

   assign accept      = cmd_valid && cmd_ok;
   assign refresh_due = (refi_ct == '0);

   always_comb begin
      bank_state = '0;
      for (int unsigned i = 0; i < NBANKS; i++)
         bank_state[2*i +: 2] = st[BW'(i)];
   end

   always_comb begin
      wsum     = (CW+2)'(nz(T_CWL)) + (CW+2)'(BL) + (CW+2)'(nz(T_WR));
      wr_sat   = (wsum > SATMAX) ? '1 : wsum[CW-1:0];
      wr_guard = wr_sat - CW'(1);
      rd_guard = ld(T_RTP);
   end

   always_comb begin
      all_idle   = 1'b1;
      prea_ready = 1'b1;
      faw_free   = 1'b0;
      faw_sel    = '0;
      for (int unsigned i = 0; i < NBANKS; i++) begin
         if (st[BW'(i)] != IDLE)
            all_idle = 1'b0;
         if (!(st[BW'(i)] == IDLE ||
               (st[BW'(i)] == ACTIVE && ras_ct[BW'(i)] == '0 && guard_ct[BW'(i)] == '0)))
            prea_ready = 1'b0;
      end
      for (int unsigned i = 0; i < 4; i++) begin
         if (faw_ct[2'(i)] == '0 && !faw_free) begin
            faw_free = 1'b1;
            faw_sel  = 2'(i);
         end
      end
   end

   always_comb begin
      b_st    = st[cmd_bank];
      b_ready = (b_st == ACTIVE) && (ras_ct[cmd_bank] == '0) && (guard_ct[cmd_bank] == '0);
      cmd_ok  = 1'b0;
      if (refreshing) begin
         cmd_ok = (cmd_op == OP_NOP);
      end else begin
         case (cmd_op)
            OP_NOP:        cmd_ok = 1'b1;
            OP_ACT:        cmd_ok = (b_st == IDLE) && (rrd_ct == '0) && faw_free && !b_ap;
            OP_RD, OP_WR:  cmd_ok = (b_st == ACTIVE) && !b_ap;
            OP_PRE:        cmd_ok = !b_ap && ((b_st == IDLE) || b_ready);
            OP_PREA:       cmd_ok = prea_ready && !any_ap;
            OP_REF:        cmd_ok = all_idle;
`ifdef MEM_BANK_TIMING_AUTOPRE_EN
            OP_RDA, OP_WRA: cmd_ok = (b_st == ACTIVE) && !b_ap;
`endif
            default:       cmd_ok = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NBANKS; i++) begin
            st[BW'(i)]       <= IDLE;
            rcd_ct[BW'(i)]   <= '0;
            ras_ct[BW'(i)]   <= '0;
            rp_ct[BW'(i)]    <= '0;
            guard_ct[BW'(i)] <= '0;
         end
         for (int unsigned i = 0; i < 4; i++)
            faw_ct[2'(i)] <= '0;
`ifdef MEM_BANK_TIMING_AUTOPRE_EN
         ap_pending <= '0;
`endif
         rrd_ct     <= '0;
         rfc_ct     <= '0;
         refi_ct    <= T_REFI;
         refreshing <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         cmd_err <= cmd_valid && !cmd_ok;
         refi_ct <= (refi_ct == '0) ? '0 : refi_ct - RW'(1);
         rrd_ct  <= dec(rrd_ct);
         rfc_ct  <= dec(rfc_ct);
         for (int unsigned i = 0; i < 4; i++)
            faw_ct[2'(i)] <= dec(faw_ct[2'(i)]);
         if (refreshing && rfc_ct <= CW'(1))
            refreshing <= 1'b0;

         for (int unsigned i = 0; i < NBANKS; i++) begin
            rcd_ct[BW'(i)]   <= dec(rcd_ct[BW'(i)]);
            ras_ct[BW'(i)]   <= dec(ras_ct[BW'(i)]);
            rp_ct[BW'(i)]    <= dec(rp_ct[BW'(i)]);
            guard_ct[BW'(i)] <= dec(guard_ct[BW'(i)]);
            case (st[BW'(i)])
               ACTIVATING:  if (rcd_ct[BW'(i)] <= CW'(1)) st[BW'(i)] <= ACTIVE;
               PRECHARGING: if (rp_ct[BW'(i)] <= CW'(1))  st[BW'(i)] <= IDLE;
`ifdef MEM_BANK_TIMING_AUTOPRE_EN
               ACTIVE: begin
                  if (ap_pending[BW'(i)] && ras_ct[BW'(i)] == '0 && guard_ct[BW'(i)] == '0) begin
                     st[BW'(i)]         <= PRECHARGING;
                     rp_ct[BW'(i)]      <= nz(T_RP);
                     ap_pending[BW'(i)] <= 1'b0;
                  end
               end
`endif
               default: ;
            endcase
         end

         if (accept) begin
            case (cmd_op)
               OP_ACT: begin
                  st[cmd_bank]     <= ACTIVATING;
                  rcd_ct[cmd_bank] <= nz(T_RCD);
                  ras_ct[cmd_bank] <= ld(T_RAS);
                  rrd_ct           <= ld(T_RRD);
                  faw_ct[faw_sel]  <= ld(T_FAW);
               end
               OP_RD: guard_ct[cmd_bank] <= gmax(guard_ct[cmd_bank], rd_guard);
               OP_WR: guard_ct[cmd_bank] <= gmax(guard_ct[cmd_bank], wr_guard);
               OP_PRE: begin
                  if (b_st == ACTIVE) begin
                     st[cmd_bank]    <= PRECHARGING;
                     rp_ct[cmd_bank] <= nz(T_RP);
                  end
               end
               OP_PREA: begin
                  for (int unsigned i = 0; i < NBANKS; i++) begin
                     if (st[BW'(i)] == ACTIVE) begin
                        st[BW'(i)]    <= PRECHARGING;
                        rp_ct[BW'(i)] <= nz(T_RP);
                     end
                  end
               end
               OP_REF: begin
                  refreshing <= 1'b1;
                  rfc_ct     <= nz(T_RFC);
                  refi_ct    <= T_REFI;
               end
`ifdef MEM_BANK_TIMING_AUTOPRE_EN
               OP_RDA: begin
                  guard_ct[cmd_bank]   <= gmax(guard_ct[cmd_bank], rd_guard);
                  ap_pending[cmd_bank] <= 1'b1;
               end
               OP_WRA: begin
                  guard_ct[cmd_bank]   <= gmax(guard_ct[cmd_bank], wr_guard);
                  ap_pending[cmd_bank] <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_bank_timing.sv
// Directed bench for mem_bank_timing; cycle 0 is the first cycle after reset releases.
module tb_mem_bank_timing;
   localparam int unsigned NBANKS = 8;
   localparam int unsigned CW     = 8;
   localparam int unsigned RW     = 16;
   localparam int unsigned BL     = 8;

   localparam logic [3:0] OP_NOP = 4'd0, OP_ACT = 4'd1, OP_RD = 4'd2, OP_WR = 4'd3,
                          OP_PRE = 4'd4, OP_PREA = 4'd5, OP_REF = 4'd6, OP_RDA = 4'd7;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic [3:0]           cmd_op = '0;
   logic [2:0]           cmd_bank = '0;
   logic [CW-1:0]        T_RCD, T_RAS, T_RP, T_RTP, T_WR, T_CWL, T_RRD, T_FAW, T_RFC;
   logic [RW-1:0]        T_REFI;
   logic                 cmd_ok, cmd_err, refreshing, refresh_due;
   logic [2*NBANKS-1:0]  bank_state;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   mem_bank_timing #(.NBANKS(NBANKS), .CW(CW), .RW(RW), .BL(BL)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
      .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP), .T_RTP(T_RTP), .T_WR(T_WR),
      .T_CWL(T_CWL), .T_RRD(T_RRD), .T_FAW(T_FAW), .T_RFC(T_RFC), .T_REFI(T_REFI),
      .cmd_ok(cmd_ok), .cmd_err(cmd_err), .bank_state(bank_state),
      .refreshing(refreshing), .refresh_due(refresh_due)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one command for the next cycle, then settle before checking.
   task automatic cyc(input logic v, input logic [3:0] op, input logic [2:0] b);
      @(negedge clk);
      rst = 1'b0; cmd_valid = v; cmd_op = op; cmd_bank = b;
      #1;
   endtask

   task automatic nop();
      cyc(1'b0, OP_NOP, 3'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_bank = '0;
      @(negedge clk);
   endtask

   function automatic logic [1:0] bst(input int unsigned b);
      return bank_state[2*b +: 2];
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      T_RCD = 8'd3; T_RAS = 8'd6; T_RP = 8'd2; T_RTP = 8'd2; T_WR = 8'd4; T_CWL = 8'd2;
      T_RRD = 8'd2; T_FAW = 8'd10; T_RFC = 8'd5; T_REFI = 16'd20;

      // Row cycle on bank 0: tRCD dwell, early PRE rejection, tRP dwell
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);                    // c0
      check("rst_banks", 32'(bank_state), 32'h0);
      check("rst_refreshing", 32'(refreshing), 32'h0);
      check("rst_err", 32'(cmd_err), 32'h0);
      check("rst_due", 32'(refresh_due), 32'h0);
      check("act_ok", 32'(cmd_ok), 32'h1);
      for (int c = 1; c <= 3; c++) begin
         cyc(1'b0, OP_RD, 3'd0);
         check("activating", 32'(bst(0)), 32'h1);
         check("rd_activating_ok", 32'(cmd_ok), 32'h0);
      end
      cyc(1'b1, OP_PRE, 3'd0);                    // c4
      check("active_c4", 32'(bst(0)), 32'h2);
      check("pre_early_ok", 32'(cmd_ok), 32'h0);
      nop();                                      // c5
      check("pre_early_err", 32'(cmd_err), 32'h1);
      cyc(1'b1, OP_PRE, 3'd0);                    // c6
      check("pre_c6_ok", 32'(cmd_ok), 32'h1);
      nop();                                      // c7
      check("err_clears", 32'(cmd_err), 32'h0);
      check("prech_c7", 32'(bst(0)), 32'h3);
      nop();                                      // c8
      check("prech_c8", 32'(bst(0)), 32'h3);
      nop();                                      // c9
      check("idle_c9", 32'(bst(0)), 32'h0);

      // tRRD / tFAW spacing
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);                    // c0
      check("faw_act0", 32'(cmd_ok), 32'h1);
      cyc(1'b0, OP_ACT, 3'd1);                    // c1
      check("rrd_block", 32'(cmd_ok), 32'h0);
      cyc(1'b1, OP_ACT, 3'd1); check("faw_act1", 32'(cmd_ok), 32'h1);   // c2
      nop();
      cyc(1'b1, OP_ACT, 3'd2); check("faw_act2", 32'(cmd_ok), 32'h1);   // c4
      nop();
      cyc(1'b1, OP_ACT, 3'd3); check("faw_act3", 32'(cmd_ok), 32'h1);   // c6
      nop();
      cyc(1'b1, OP_ACT, 3'd4); check("faw_block_c8", 32'(cmd_ok), 32'h0); // c8
      cyc(1'b0, OP_ACT, 3'd4);                    // c9
      check("faw_err", 32'(cmd_err), 32'h1);
      check("faw_block_c9", 32'(cmd_ok), 32'h0);
      cyc(1'b1, OP_ACT, 3'd4); check("faw_free_c10", 32'(cmd_ok), 32'h1); // c10

      // Write recovery guard: 2 + 8 + 4 = 14
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);
      repeat (3) nop();
      cyc(1'b1, OP_WR, 3'd0);                     // c4
      check("wr_ok", 32'(cmd_ok), 32'h1);
      for (int c = 5; c <= 18; c++) begin
         cyc(c == 18, OP_PRE, 3'd0);
         check("pre_after_wr", 32'(cmd_ok), (c >= 18) ? 32'h1 : 32'h0);
      end
      nop();                                      // c19
      check("wr_prech", 32'(bst(0)), 32'h3);

      // Saturated guard: 250 + 8 + 250 clamps to 255
      T_CWL = 8'd250; T_WR = 8'd250;
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);
      repeat (3) nop();
      cyc(1'b1, OP_WR, 3'd0);                     // c4
      for (int c = 5; c <= 259; c++) begin
         cyc(c == 259, OP_PRE, 3'd0);
         if (c == 258) check("sat_pre_c258", 32'(cmd_ok), 32'h0);
         if (c == 259) check("sat_pre_c259", 32'(cmd_ok), 32'h1);
      end
      nop();
      check("sat_prech", 32'(bst(0)), 32'h3);
      T_CWL = 8'd2; T_WR = 8'd4;

      // Refresh interval, REF legality, refresh window
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);                    // c0
      for (int c = 1; c <= 19; c++) begin
         nop();
         if (c == 19) check("due_c19", 32'(refresh_due), 32'h0);
      end
      cyc(1'b1, OP_REF, 3'd0);                    // c20
      check("due_c20", 32'(refresh_due), 32'h1);
      check("ref_active_bank", 32'(cmd_ok), 32'h0);
      cyc(1'b1, OP_PREA, 3'd0);                   // c21
      check("ref_err", 32'(cmd_err), 32'h1);
      check("prea_ok", 32'(cmd_ok), 32'h1);
      nop();                                      // c22
      check("prea_prech", 32'(bst(0)), 32'h3);
      nop();                                      // c23
      cyc(1'b1, OP_REF, 3'd0);                    // c24
      check("prea_idle", 32'(bst(0)), 32'h0);
      check("ref_ok", 32'(cmd_ok), 32'h1);
      cyc(1'b1, OP_ACT, 3'd1);                    // c25
      check("refreshing_c25", 32'(refreshing), 32'h1);
      check("act_in_refresh", 32'(cmd_ok), 32'h0);
      check("refi_reload", 32'(refresh_due), 32'h0);
      cyc(1'b1, OP_NOP, 3'd0);                    // c26
      check("act_refresh_err", 32'(cmd_err), 32'h1);
      check("nop_in_refresh", 32'(cmd_ok), 32'h1);
      nop(); nop(); nop();                        // c27..c29
      check("refreshing_c29", 32'(refreshing), 32'h1);
      cyc(1'b0, OP_ACT, 3'd1);                    // c30
      check("refresh_done", 32'(refreshing), 32'h0);
      check("act_after_refresh", 32'(cmd_ok), 32'h1);
      for (int c = 31; c <= 45; c++) begin
         nop();
         if (c == 44) check("due_c44", 32'(refresh_due), 32'h0);
         if (c == 45) check("due_c45", 32'(refresh_due), 32'h1);
      end

      // RDA handling, with and without auto precharge
      T_RAS = 8'd8;
      do_reset();
      cyc(1'b1, OP_ACT, 3'd0);
      repeat (4) nop();
      cyc(1'b1, OP_RDA, 3'd0);                    // c5
`ifdef MEM_BANK_TIMING_AUTOPRE_EN
      check("rda_ok", 32'(cmd_ok), 32'h1);
      cyc(1'b1, OP_RD, 3'd0);                     // c6
      check("rd_ap_pending", 32'(cmd_ok), 32'h0);
      nop();                                      // c7
      check("rd_ap_err", 32'(cmd_err), 32'h1);
      check("ap_active_c7", 32'(bst(0)), 32'h2);
      nop(); nop();                               // c9
      check("ap_prech_c9", 32'(bst(0)), 32'h3);
      cyc(1'b1, 4'd12, 3'd1);                     // c10
      check("reserved_op", 32'(cmd_ok), 32'h0);
      nop();                                      // c11
      check("reserved_err", 32'(cmd_err), 32'h1);
      check("ap_idle_c11", 32'(bst(0)), 32'h0);
`else
      check("rda_illegal", 32'(cmd_ok), 32'h0);
      cyc(1'b1, OP_RD, 3'd0);                     // c6
      check("rda_err", 32'(cmd_err), 32'h1);
      check("rda_no_effect", 32'(bst(0)), 32'h2);
      check("rd_ok", 32'(cmd_ok), 32'h1);
      nop(); nop(); nop();                        // c9
      check("no_autopre_c9", 32'(bst(0)), 32'h2);
      cyc(1'b1, 4'd12, 3'd1);                     // c10
      check("reserved_op", 32'(cmd_ok), 32'h0);
      nop();                                      // c11
      check("reserved_err", 32'(cmd_err), 32'h1);
      check("still_active_c11", 32'(bst(0)), 32'h2);
`endif
      T_RAS = 8'd6;

      // Reset during refresh and during activation
      do_reset();
      cyc(1'b1, OP_REF, 3'd0);                    // c0
      nop();                                      // c1
      check("pre_rst_refreshing", 32'(refreshing), 32'h1);
      do_reset();
      nop();                                      // c0
      check("rst_mid_refresh", 32'(refreshing), 32'h0);
      check("rst_mid_due", 32'(refresh_due), 32'h0);
      for (int c = 1; c <= 20; c++) begin
         if (c == 20) cyc(1'b1, OP_ACT, 3'd3); else nop();
         if (c == 19) check("rst_refi_c19", 32'(refresh_due), 32'h0);
         if (c == 20) check("rst_refi_c20", 32'(refresh_due), 32'h1);
      end
      nop();
      check("pre_rst_activating", 32'(bst(3)), 32'h1);
      do_reset();
      nop();
      check("rst_mid_act", 32'(bank_state), 32'h0);
      check("rst_mid_act_err", 32'(cmd_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_bank_timing.md
Name: mem_bank_timing

Overview:
- Multi-bank successor to the single-bank memory timing FSM.
- Tracks per-bank row state and per-bank timing counters for NBANKS banks.
- Enforces inter-bank ACT spacing (tRRD, tFAW) and all-bank refresh (tRFC, tREFI).
- Sits between the command decoder and the bank arrays; reports per cycle whether the presented command is timing-legal.

Parameters:
- NBANKS, 8, number of banks (power of two, 2..16)
- CW, 8, width of timing inputs and per-bank counters
- RW, 16, width of refresh-interval counter
- BL, 8, burst length in clocks, added to the write-recovery guard

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command presented this cycle
- cmd_op  in  4  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 RDA, 8 WRA; 9-15 reserved
- cmd_bank  in  $clog2(NBANKS)  target bank
- T_RCD, T_RAS, T_RP, T_RTP, T_WR, T_CWL, T_RRD, T_FAW, T_RFC  in  CW each  timing values in clocks
- T_REFI  in  RW  refresh interval
- cmd_ok  out  1  combinational: presented command is legal now
- cmd_err  out  1  registered pulse, one cycle after a valid, illegal command
- bank_state  out  2*NBANKS  per bank: 0 IDLE, 1 ACTIVATING, 2 ACTIVE, 3 PRECHARGING
- refreshing  out  1  all-bank refresh in progress
- refresh_due  out  1  refresh-interval counter has reached 0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - all banks IDLE; all counters 0; refreshing=0; cmd_err=0
  - refi_ct loads T_REFI; all four FAW slots cleared
- Timing values are sampled at command acceptance; a value of 0 is treated as 1.
- Acceptance: a command is accepted when cmd_valid && cmd_ok. NOP is always ok.
  - Illegal commands have no state effect; cmd_err=1 on the next cycle only.
- Legality is computed on current register values only. A counter expiring in the same cycle does not make the command legal until the next cycle.
- Per-bank counters: rcd_ct, ras_ct, rp_ct, guard_ct. All decrement by 1 per cycle, saturating at 0.
- ACT(b):
  - Legal when: bank b IDLE, rrd_ct==0, at least one FAW slot is 0, refreshing=0.
  - Effect: bank b -> ACTIVATING; rcd_ct=T_RCD, ras_ct=T_RAS, rrd_ct=T_RRD; one zero FAW slot (lowest index) loads T_FAW.
  - A bank in ACTIVATING whose rcd_ct==1 moves to ACTIVE next cycle, so it dwells exactly T_RCD cycles.
- RD(b) / WR(b):
  - Legal when bank b is ACTIVE.
  - RD: guard_ct = max(guard_ct, T_RTP).
  - WR: guard_ct = max(guard_ct, sat(T_CWL+BL+T_WR)), where sat clamps to 2^CW-1.
- PRE(b):
  - Legal when bank b is IDLE (no effect), or bank b is ACTIVE with ras_ct==0 and guard_ct==0.
  - Active case: bank -> PRECHARGING, rp_ct=T_RP. It moves to IDLE after the cycle with rp_ct==1 (dwell T_RP).
- PREA: legal when every bank is IDLE, or ACTIVE with ras_ct==0 and guard_ct==0. Every ACTIVE bank precharges as for PRE.
- REF:
  - Legal when all banks are IDLE and refreshing=0.
  - Effect: refreshing=1 with rfc_ct=T_RFC; refi_ct reloads T_REFI. refreshing clears after the cycle with rfc_ct==1.
  - While refreshing, only NOP is legal.
- refi_ct decrements every cycle, saturating at 0. refresh_due=(refi_ct==0); there is no auto-issue.
- FAW: four slot counters, each decrementing to 0. While all four are nonzero, no ACT is legal.
- rst asserted mid-operation overrides everything, including an in-flight refresh or a pending auto-precharge.

Optional Feature:
- MEM_BANK_TIMING_AUTOPRE_EN defined:
  - RDA/WRA are legal under the same conditions as RD/WR, with the same guard update.
  - They also set the bank's ap_pending flag. While ap_pending=1, any command to that bank is illegal.
  - When ras_ct==0 and guard_ct==0, the bank enters PRECHARGING automatically (rp_ct=T_RP) and ap_pending clears.
  - PREA is illegal while any ap_pending is set.
- Not defined: opcodes 7 and 8 are illegal (cmd_ok=0, cmd_err pulses); there is no ap_pending state.

Test Plan:
- T_RCD=3, T_RAS=6, T_RP=2: ACT b0 at cycle 0 -> bank_state[1:0]=1 for cycles 1-3, =2 from cycle 4. PRE at cycle 4 -> illegal, cmd_err=1 at cycle 5. PRE at cycle 6 -> PRECHARGING at cycles 7-8, IDLE at cycle 9.
- T_RRD=2, T_FAW=10: ACT to b0,b1,b2,b3 at cycles 0,2,4,6 -> all ok. ACT b4 at cycle 8 -> cmd_ok=0. ACT b4 at cycle 10 -> ok.
- WR b0 with T_CWL=2, BL=8, T_WR=4: guard=14. PRE is rejected for 14 cycles after the write and accepted at cycle +14. Saturation check: T_CWL=T_WR=250 -> guard=255.
- T_REFI=20: refresh_due rises at cycle 20. REF issued with one bank ACTIVE -> rejected. After PREA and return to all-IDLE, REF (T_RFC=5) -> refreshing for 5 cycles; ACT during that window is rejected; refi_ct reloads to 20.
- AUTOPRE_EN, T_RAS=8, T_RTP=2: RDA issued at cycle 5 after ACT at cycle 0 -> auto precharge starts at cycle 8; RD to that bank at cycle 6 -> cmd_err. Without the macro: RDA -> cmd_err, bank_state unchanged.
- Assert rst during REFRESHING and during ACTIVATING -> next cycle all banks IDLE, refreshing=0, refi_ct=T_REFI.
